// File: rtl/dma_controller_pkg.sv
// Shared types and defaults for the DMA controller: state encoding, sizes and
// the destination address helper.
package dma_controller_pkg;

  localparam int WORD_SIZE     = 16;
  localparam int DMA_NUM_WORDS = 12;
  localparam int DMA_WR_LAT    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } dma_fsm_e;

  // Destination address of word idx; wraps modulo 2^WORD_SIZE by construction.
  function automatic logic [WORD_SIZE-1:0] addr_of(input logic [WORD_SIZE-1:0] base,
                                                   input logic [3:0] idx);
    return base + {{(WORD_SIZE-4){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/dma_controller_if.sv
// CPU command, bus arbitration, device and memory-write signals of the DMA engine.
interface dma_controller_if;
  import dma_controller_pkg::*;

  logic                 cmd_valid;
  logic [WORD_SIZE-1:0] cmd_addr;
  logic                 busy;
  logic                 BR;
  logic                 BG;
  logic [3:0]           dma_state;
  logic [WORD_SIZE-1:0] dev_data;
  logic                 dev_rd;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_data;
  logic                 mem_we;
  logic                 dma_end;

  modport master (
    input  cmd_valid, cmd_addr, BG, dev_data,
    output busy, BR, dma_state, dev_rd, mem_addr, mem_data, mem_we, dma_end
  );

  modport slave (
    output cmd_valid, cmd_addr, BG, dev_data,
    input  busy, BR, dma_state, dev_rd, mem_addr, mem_data, mem_we, dma_end
  );

endinterface

// File: rtl/dma_controller_word_counter.sv
// Per-word latency counter and word index counter of the DMA engine.
module dma_controller_word_counter #(
  parameter int NUM_WORDS = 12,
  parameter int WR_LAT    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] word_cnt,
  output logic       word_done,
  output logic       last_word
);

  logic [2:0] lat_cnt_r;
  logic [3:0] word_cnt_r;
  logic       word_done_s;
  logic       last_word_s;

  assign word_done_s = en && (lat_cnt_r == 3'(WR_LAT - 1));
  assign last_word_s = (word_cnt_r == 4'(NUM_WORDS - 1));

  // Counters freeze while en is low so a paused word keeps its partial latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt_r  <= 3'd0;
      word_cnt_r <= 4'd0;
    end else if (clear) begin
      lat_cnt_r  <= 3'd0;
      word_cnt_r <= 4'd0;
    end else if (word_done_s) begin
      lat_cnt_r  <= 3'd0;
      word_cnt_r <= last_word_s ? 4'd0 : word_cnt_r + 4'd1;
    end else if (en) begin
      lat_cnt_r  <= lat_cnt_r + 3'd1;
    end else begin
      lat_cnt_r  <= lat_cnt_r;
      word_cnt_r <= word_cnt_r;
    end
  end

  assign word_cnt  = word_cnt_r;
  assign word_done = word_done_s;
  assign last_word = last_word_s;

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA engine: on a CPU command it requests the bus and copies
// NUM_WORDS device words into memory starting at the commanded base address.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int NUM_WORDS = DMA_NUM_WORDS,
  parameter int WR_LAT    = DMA_WR_LAT
) (
  input logic              clk,
  input logic              reset_n,
  dma_controller_if.master bus
);

  dma_fsm_e             state_r;
  dma_fsm_e             state_s;
  logic [WORD_SIZE-1:0] base_r;
  logic                 br_r;
  logic                 busy_r;
  logic                 dma_end_r;
  logic                 cmd_accept_s;
  logic                 cnt_clear_s;
  logic                 mem_we_s;
  logic                 word_done_s;
  logic                 last_word_s;
  logic [3:0]           word_cnt_s;

  dma_controller_word_counter #(
    .NUM_WORDS (NUM_WORDS),
    .WR_LAT    (WR_LAT)
  ) u_word_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (cnt_clear_s),
    .en        (mem_we_s),
    .word_cnt  (word_cnt_s),
    .word_done (word_done_s),
    .last_word (last_word_s)
  );

  // Write strobe follows the grant directly; a dropped grant pauses the word.
  always_comb begin
    mem_we_s = 1'b0;
    if (state_r == ST_XFER) begin
      mem_we_s = bus.BG;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Next-state logic; commands are only accepted from IDLE.
  always_comb begin
    state_s      = state_r;
    cmd_accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_accept_s = 1'b1;
          state_s      = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.BG) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_XFER: begin
        if (word_done_s && last_word_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign cnt_clear_s = cmd_accept_s | (state_r == ST_DONE);

  // State, base address and the registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      base_r    <= {WORD_SIZE{1'b0}};
      br_r      <= 1'b0;
      busy_r    <= 1'b0;
      dma_end_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      base_r    <= cmd_accept_s ? bus.cmd_addr : base_r;
      br_r      <= (state_s == ST_REQ) || (state_s == ST_XFER);
      busy_r    <= (state_s != ST_IDLE);
      dma_end_r <= (state_s == ST_DONE);
    end
  end

  assign bus.BR        = br_r;
  assign bus.busy      = busy_r;
  assign bus.dma_end   = dma_end_r;
  assign bus.dma_state = word_cnt_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.dev_rd    = word_done_s;
  assign bus.mem_data  = bus.dev_data;
  assign bus.mem_addr  = (state_r == ST_XFER) ? addr_of(base_r, word_cnt_s) : {WORD_SIZE{1'b0}};

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: nominal, delayed grant, grant pause,
// ignored commands, mid-transfer reset and address wrap.
module tb_dma_controller;

  localparam int NW = 12;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        cmd_v;
  logic [15:0] cmd_addr;
  logic        follow;
  logic        bg_man;
  logic        dev_clr;
  logic [15:0] dev_idx;
  int          vectors;
  int          miscompares;
  int          cyc;

  logic        obs_busy, obs_br, obs_we, obs_rd, obs_end;
  logic [3:0]  obs_state;
  logic [15:0] obs_addr, obs_data;

  dma_controller_if bus0 ();
  dma_controller_if bus1 ();

  dma_controller #(.NUM_WORDS(NW), .WR_LAT(2)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  dma_controller #(.NUM_WORDS(NW), .WR_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  assign bus0.cmd_valid = cmd_v & ~sel;
  assign bus1.cmd_valid = cmd_v & sel;
  assign bus0.cmd_addr  = cmd_addr;
  assign bus1.cmd_addr  = cmd_addr;
  assign bus0.BG        = follow ? bus0.BR : bg_man;
  assign bus1.BG        = follow ? bus1.BR : bg_man;
  assign bus0.dev_data  = 16'hA000 + dev_idx;
  assign bus1.dev_data  = 16'hA000 + dev_idx;

  assign obs_busy  = sel ? bus1.busy      : bus0.busy;
  assign obs_br    = sel ? bus1.BR        : bus0.BR;
  assign obs_we    = sel ? bus1.mem_we    : bus0.mem_we;
  assign obs_rd    = sel ? bus1.dev_rd    : bus0.dev_rd;
  assign obs_end   = sel ? bus1.dma_end   : bus0.dma_end;
  assign obs_state = sel ? bus1.dma_state : bus0.dma_state;
  assign obs_addr  = sel ? bus1.mem_addr  : bus0.mem_addr;
  assign obs_data  = sel ? bus1.mem_data  : bus0.mem_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device model: advances to its next word on every dev_rd pulse.
  always @(posedge clk) begin
    if (dev_clr) dev_idx <= 16'd0;
    else if (obs_rd) dev_idx <= dev_idx + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(obs_busy),  32'd0);
    chk({tag, "_br"},    32'(obs_br),    32'd0);
    chk({tag, "_we"},    32'(obs_we),    32'd0);
    chk({tag, "_rd"},    32'(obs_rd),    32'd0);
    chk({tag, "_end"},   32'(obs_end),   32'd0);
    chk({tag, "_state"}, 32'(obs_state), 32'd0);
    chk({tag, "_addr"},  32'(obs_addr),  32'd0);
  endtask

  // ph: 0 idle, 1 req, 2 xfer, 3 done; k counts granted write cycles.
  task automatic run_xfer(input logic s, input logic [15:0] base, input int lat, input logic fol,
                          input int bg_start, input int gap_s, input int gap_len,
                          input logic inject, input int rst_word, input int exp_end);
    int ph, k, w, we_cnt, rd_cnt, end_cyc;
    logic bg, exp_we, done;
    logic [15:0] ea;
    sel = s; ph = 0; k = 0; we_cnt = 0; rd_cnt = 0; end_cyc = -1; done = 1'b0;
    @(negedge clk);
    cyc = 0; cmd_v = 1'b1; cmd_addr = base; dev_clr = 1'b1; follow = fol; bg_man = 1'b0;
    #1;
    chk("busy_cmd_cycle", 32'(obs_busy), 32'd0);
    ph = 1;
    for (int c = 1; c < 200 && !done; c++) begin
      @(negedge clk);
      cyc = c; cmd_v = 1'b0; dev_clr = 1'b0;
      bg = fol ? (ph == 1 || ph == 2) : (c >= bg_start && !(c >= gap_s && c < gap_s + gap_len));
      bg_man = bg;
      if (inject && ((ph == 2 && k == 5 * lat) || ph == 3)) begin
        cmd_v = 1'b1; cmd_addr = 16'h0200;
      end
      if (rst_word >= 0 && ph == 2 && k == rst_word * lat) begin
        reset_n = 1'b0;
        #1;
        chk("rst_br", 32'(obs_br), 32'd0);
        chk("rst_we", 32'(obs_we), 32'd0);
        chk("rst_state", 32'(obs_state), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_addr", 32'(obs_addr), 32'd0);
        repeat (2) begin
          @(negedge clk); #1;
          chk("rst_hold_end", 32'(obs_end), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
          @(negedge clk); #1;
          chk_idle("post_rst");
        end
        done = 1'b1;
      end else begin
        #1;
        w = k / lat;
        ea = base + 16'(w);
        exp_we = (ph == 2) && bg;
        chk("br",      32'(obs_br),    32'(ph == 1 || ph == 2));
        chk("busy",    32'(obs_busy),  32'(ph != 0));
        chk("dma_end", 32'(obs_end),   32'(ph == 3));
        chk("mem_we",  32'(obs_we),    32'(exp_we));
        chk("dev_rd",  32'(obs_rd),    32'(exp_we && (k % lat == lat - 1)));
        chk("dma_state", 32'(obs_state), (ph == 2) ? 32'(w) : 32'd0);
        if (ph == 2) chk("mem_addr", 32'(obs_addr), 32'(ea));
        if (exp_we) chk("mem_data", 32'(obs_data), 32'(16'hA000 + 16'(w)));
        if (obs_we) we_cnt++;
        if (obs_rd) rd_cnt++;
        if (obs_end) end_cyc = c;
        if (ph == 0) begin
          done = 1'b1;
        end else if (ph == 3) begin
          ph = 0;
        end else if (ph == 2) begin
          if (exp_we) k++;
          if (k == NW * lat) ph = 3;
        end else if (bg) begin
          ph = 2;
        end
      end
    end
    chk("finished_in_budget", 32'(done), 32'd1);
    if (rst_word < 0) begin
      chk("dma_end_cycle", 32'(end_cyc), 32'(exp_end));
      chk("we_cycles", 32'(we_cnt), 32'(NW * lat));
      chk("dev_rd_pulses", 32'(rd_cnt), 32'(NW));
    end
    cmd_v = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    reset_n = 1'b0; sel = 1'b0; cmd_v = 1'b0; cmd_addr = 16'h0000;
    follow = 1'b0; bg_man = 1'b0; dev_clr = 1'b1;
    #12;
    chk_idle("reset_a");
    sel = 1'b1; #1;
    chk_idle("reset_b");
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // nominal: BG tied to BR, dma_end at cycle 26
    run_xfer(1'b0, 16'h0100, 2, 1'b1, 0, 1000, 0, 1'b0, -1, 26);
    // grant arrives 5 cycles after BR
    run_xfer(1'b0, 16'h0100, 2, 1'b0, 6, 1000, 0, 1'b0, -1, 31);
    // grant dropped for 3 cycles with word 4 half written
    run_xfer(1'b0, 16'h0100, 2, 1'b0, 1, 11, 3, 1'b0, -1, 29);
    // commands during XFER and DONE are ignored
    run_xfer(1'b0, 16'h0100, 2, 1'b1, 0, 1000, 0, 1'b1, -1, 26);
    // a command from IDLE then takes the new base
    run_xfer(1'b0, 16'h0200, 2, 1'b1, 0, 1000, 0, 1'b0, -1, 26);
    // asynchronous reset during word 7
    run_xfer(1'b0, 16'h0100, 2, 1'b1, 0, 1000, 0, 1'b0, 7, 0);
    // address wrap with single-cycle writes
    run_xfer(1'b1, 16'hFFFA, 1, 1'b1, 0, 1000, 0, 1'b0, -1, 14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_controller.md
Name: dma_controller

Overview:
- Bus-master DMA engine that moves a fixed-length block of words from an external device into data memory.
- Upstream of the pipeline's hazard/stall unit. It drives the `BR` (bus request) and `dma_state` (word index) inputs that the hazard unit uses to enter and leave its INTERRUPT stall, and it consumes `BG` (bus grant).
- The CPU issues a one-cycle command carrying the destination base address. The block requests the bus, writes `NUM_WORDS` words, releases the bus and pulses an end-of-transfer interrupt.

Parameters:
- `WORD_SIZE`, 16, data/address width.
- `NUM_WORDS`, 12, words per transfer. Legal range 1..16. The hazard unit's exit test expects `dma_state == NUM_WORDS-1`.
- `WR_LAT`, 2, cycles each memory write is held (memory write latency). Legal range 1..8.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  one-cycle DMA start command from CPU.
- `cmd_addr`  in  WORD_SIZE  destination base address, sampled with `cmd_valid`.
- `busy`  out  1  high from command acceptance until return to IDLE.
- `BR`  out  1  bus request to CPU/hazard unit.
- `BG`  in  1  bus grant from CPU.
- `dma_state`  out  4  index of the word currently being written (0..NUM_WORDS-1).
- `dev_data`  in  WORD_SIZE  current device word, valid while presented.
- `dev_rd`  out  1  one-cycle pulse telling the device to advance to its next word.
- `mem_addr`  out  WORD_SIZE  memory write address.
- `mem_data`  out  WORD_SIZE  memory write data, equal to `dev_data`.
- `mem_we`  out  1  memory write enable.
- `dma_end`  out  1  one-cycle end-of-transfer interrupt.

Behaviour:
- Reset (asynchronous, any state, mid-transfer included):
  - state = IDLE; `base`, `word_cnt`, `lat_cnt` = 0.
  - `BR` = `busy` = `mem_we` = `dev_rd` = `dma_end` = 0; `dma_state` = 0; `mem_addr` = 0.
  - No partial-transfer completion and no `dma_end` after reset.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - `cmd_valid` = 1 latches `cmd_addr` into `base`, clears `word_cnt`/`lat_cnt`, and moves to REQ on the next edge.
  - `cmd_valid` in any other state is ignored; `base` is unchanged.
- REQ:
  - `BR` = 1 and `busy` = 1, both registered, so they are visible from the first REQ cycle.
  - `BG` = 1 moves the block to XFER on the next edge. There is no timeout.
- XFER:
  - `BR` = 1; `mem_addr` = `base` + `word_cnt` (modulo 2^WORD_SIZE, wraps silently); `mem_we` = `BG` (combinational).
  - When `mem_we` = 1, `lat_cnt` increments. On the cycle where `lat_cnt` == WR_LAT-1 with `mem_we` = 1, the word is complete:
    - `dev_rd` = 1 that same cycle;
    - `lat_cnt` clears;
    - `word_cnt` increments, or the block moves to DONE if `word_cnt` == NUM_WORDS-1.
  - `BG` low mid-transfer is a pause: `mem_we` = 0, all counters are frozen, `BR` stays 1, and the partial `lat_cnt` is retained. The transfer resumes when `BG` returns.
- DONE (one cycle):
  - `BR` = 0; `dma_end` = 1; `word_cnt` cleared, so `dma_state` returns to 0; `busy` = 1.
  - Next state is IDLE. `cmd_valid` during DONE is ignored.
- `dma_state` = `word_cnt` (zero-extended to 4 bits). It holds NUM_WORDS-1 for the full final word, which lets the hazard unit leave INTERRUPT on the last write.
- Latency with `BG` held high:
  - `cmd_valid` at cycle 0 → `BR` at cycle 1 → XFER from cycle 2.
  - Last write at cycle 1 + NUM_WORDS×WR_LAT.
  - `dma_end` the next cycle.
- `dev_rd` count per transfer is exactly NUM_WORDS.

Decomposition:
- Shared include `dma_defs.v`:
  - state encodings IDLE/REQ/XFER/DONE (2 bits);
  - `DMA_NUM_WORDS` and `DMA_WR_LAT` defaults;
  - reuse of the `WORD_SIZE` define.
- One natural sub-module, `dma_word_counter`: it owns `lat_cnt`/`word_cnt`, takes enable = `mem_we`, and outputs `word_done` and `last_word`. The FSM and address adder stay in the top module.

Test Plan:
- Nominal, `BG` tied to `BR`, `cmd_addr` = 0x0100, WR_LAT = 2:
  - `BR` rises at cycle 1;
  - `mem_we` is high for 24 cycles with addresses 0x0100..0x010B, each held 2 cycles;
  - 12 `dev_rd` pulses;
  - `dma_state` runs 0..11;
  - `dma_end` at cycle 26, then `BR` = 0 and `busy` drops at cycle 27.
- `BG` delayed 5 cycles after `BR`:
  - `mem_we` stays 0 and `dma_state` stays 0 while in REQ;
  - first write at 0x0100 starts the cycle after `BG` is sampled high.
- `BG` dropped for 3 cycles mid-word 4, `lat_cnt` = 1:
  - `mem_we` = 0 and `BR` = 1 during the gap;
  - `mem_addr` stays base+4 and `dma_state` stays 4;
  - one remaining latency cycle after resume;
  - total `mem_we`-high cycles still 24.
- `cmd_valid` with `cmd_addr` = 0x0200 issued during XFER and during DONE:
  - ignored; the transfer finishes at the 0x0100 range;
  - a later `cmd_valid` in IDLE starts a new transfer at 0x0200.
- `reset_n` asserted during word 7:
  - `BR`, `mem_we` and `dma_state` are 0 immediately (asynchronous);
  - no `dma_end`;
  - after release the block sits in IDLE with `busy` = 0.
- Address wrap, `cmd_addr` = 0xFFFA, WR_LAT = 1: addresses 0xFFFA..0xFFFF then 0x0000..0x0005; `dma_end` at cycle 14.
